// File: rtl/edu_aqmeas_buf_pkg.sv
// Shared constants, FSM encoding and helpers for the EDU ancilla-measurement buffer.
// Optional build macro: AQMEAS_DIFF_EN (store detection events instead of raw rounds).
package edu_aqmeas_buf_pkg;

    localparam int NUM_AQ    = 16;
    localparam int DEPTH     = 4;
    localparam int CODE_DIST = 5;
    localparam int AQMEAS_TH = 4;
    localparam int CNT_BW    = $clog2(DEPTH + 1);
    localparam int ROUND_BW  = $clog2(CODE_DIST + 1);

    typedef enum logic [1:0] {
        AQB_IDLE   = 2'b00,
        AQB_ACTIVE = 2'b01,
        AQB_DRAIN  = 2'b10
    } aqb_state_t;

    // A detection event is a change of an ancilla result between consecutive rounds.
    function automatic logic [NUM_AQ-1:0] detect_events(input logic [NUM_AQ-1:0] cur,
                                                        input logic [NUM_AQ-1:0] prev);
        return cur ^ prev;
    endfunction

endpackage

// File: rtl/edu_aqmeas_buf_fifo.sv
// DEPTH x WIDTH circular buffer with wrapping pointers and occupancy count.
// Head entry is read combinationally; push and pop may coincide, including when full.
module aqmeas_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int PTR_BW = $clog2(DEPTH);
    localparam int CNT_BW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [PTR_BW-1:0] wr_ptr_r;
    logic [PTR_BW-1:0] rd_ptr_r;
    logic [CNT_BW-1:0] count_r;
    logic [CNT_BW-1:0] count_next_s;

    // Entry storage, cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Occupancy update; push+pop together leaves it unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push, pop})
            2'b10:   count_next_s = count_r + CNT_BW'(1);
            2'b01:   count_next_s = count_r - CNT_BW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_BW{1'b0}};
            rd_ptr_r <= {PTR_BW{1'b0}};
            count_r  <= {CNT_BW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_BW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_BW'(1);
            end
            count_r <= count_next_s;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;
    assign full    = (count_r == CNT_BW'(DEPTH));

endmodule

// File: rtl/edu_aqmeas_buf.sv
// Transmit side of the EDU ancilla-measurement interface: ESM window FSM, round counter,
// overflow flag and buffer. Build macro AQMEAS_DIFF_EN stores detection events.
module edu_aqmeas_buf
    import edu_aqmeas_buf_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 esm_start,
    input  logic                 meas_valid,
    input  logic [NUM_AQ-1:0]    meas_data,
    output logic                 meas_ready,
    input  logic                 pop_aqmeasbuf,
    input  logic                 esm_finish,
    output logic                 aqmeas_valid,
    output logic [NUM_AQ-1:0]    aqmeas_data,
    output logic [CNT_BW-1:0]    aqmeas_counter,
    output logic [ROUND_BW-1:0]  round_idx,
    output logic                 ovf_err
);

    aqb_state_t          state_r;
    aqb_state_t          next_state_s;
    logic [ROUND_BW-1:0] round_idx_r;
    logic                ovf_err_r;
    logic                fifo_full_s;
    logic [CNT_BW-1:0]   fifo_count_s;
    logic                push_s;
    logic                pop_s;
    logic                start_s;
    logic                last_round_s;
    logic [NUM_AQ-1:0]   entry_s;

    assign meas_ready   = (state_r == AQB_ACTIVE) && (!fifo_full_s || pop_aqmeasbuf);
    assign push_s       = meas_valid && meas_ready;
    assign pop_s        = pop_aqmeasbuf && aqmeas_valid;
    assign start_s      = (state_r == AQB_IDLE) && esm_start;
    assign last_round_s = (round_idx_r == ROUND_BW'(CODE_DIST - 1));

    // Window FSM next state; a closing esm_finish wins over the final push.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            AQB_IDLE: begin
                if (esm_start) next_state_s = AQB_ACTIVE;
                else           next_state_s = AQB_IDLE;
            end
            AQB_ACTIVE: begin
                if (esm_finish)                  next_state_s = AQB_IDLE;
                else if (push_s && last_round_s) next_state_s = AQB_DRAIN;
                else                             next_state_s = AQB_ACTIVE;
            end
            AQB_DRAIN: begin
                if (esm_finish) next_state_s = AQB_IDLE;
                else            next_state_s = AQB_DRAIN;
            end
            default: next_state_s = AQB_IDLE;
        endcase
    end

    // State register, round counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= AQB_IDLE;
            round_idx_r <= {ROUND_BW{1'b0}};
            ovf_err_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s == AQB_IDLE) begin
                round_idx_r <= {ROUND_BW{1'b0}};
            end else if (push_s) begin
                round_idx_r <= round_idx_r + ROUND_BW'(1);
            end
            if (meas_valid && !meas_ready) begin
                ovf_err_r <= 1'b1;
            end
        end
    end

`ifdef AQMEAS_DIFF_EN
    logic [NUM_AQ-1:0] ref_r;

    // Previous accepted round; zeroed at window open so the first round is stored raw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_r <= {NUM_AQ{1'b0}};
        end else if (start_s) begin
            ref_r <= {NUM_AQ{1'b0}};
        end else if (push_s) begin
            ref_r <= meas_data;
        end
    end

    // Entry written to the buffer.
    always_comb begin
        entry_s = detect_events(meas_data, ref_r);
    end
`else
    logic unused_start_s;

    // Entry written to the buffer.
    always_comb begin
        entry_s        = meas_data;
        unused_start_s = start_s;
    end
`endif

    aqmeas_fifo #(
        .WIDTH (NUM_AQ),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (entry_s),
        .rd_data (aqmeas_data),
        .count   (fifo_count_s),
        .full    (fifo_full_s)
    );

    assign aqmeas_valid   = (fifo_count_s != {CNT_BW{1'b0}});
    assign aqmeas_counter = fifo_count_s;
    assign round_idx      = round_idx_r;
    assign ovf_err        = ovf_err_r;

endmodule

// File: tb/tb_edu_aqmeas_buf.sv
// Directed self-checking bench for edu_aqmeas_buf (honours AQMEAS_DIFF_EN if defined).
module tb_edu_aqmeas_buf;
    import edu_aqmeas_buf_pkg::*;

    logic                clk;
    logic                rst_n;
    logic                esm_start;
    logic                meas_valid;
    logic [NUM_AQ-1:0]   meas_data;
    logic                meas_ready;
    logic                pop_aqmeasbuf;
    logic                esm_finish;
    logic                aqmeas_valid;
    logic [NUM_AQ-1:0]   aqmeas_data;
    logic [CNT_BW-1:0]   aqmeas_counter;
    logic [ROUND_BW-1:0] round_idx;
    logic                ovf_err;

    int checks = 0;
    int errors = 0;

    edu_aqmeas_buf dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .esm_start      (esm_start),
        .meas_valid     (meas_valid),
        .meas_data      (meas_data),
        .meas_ready     (meas_ready),
        .pop_aqmeasbuf  (pop_aqmeasbuf),
        .esm_finish     (esm_finish),
        .aqmeas_valid   (aqmeas_valid),
        .aqmeas_data    (aqmeas_data),
        .aqmeas_counter (aqmeas_counter),
        .round_idx      (round_idx),
        .ovf_err        (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] d);
        meas_valid = 1'b1;
        meas_data  = d;
        step();
        meas_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] diff_exp [3];
        rst_n = 1'b0; esm_start = 1'b0; meas_valid = 1'b0; meas_data = 16'h0000;
        pop_aqmeasbuf = 1'b0; esm_finish = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",   32'(meas_ready),     32'd0);
        chk("rst_valid",   32'(aqmeas_valid),   32'd0);
        chk("rst_counter", 32'(aqmeas_counter), 32'd0);
        chk("rst_data",    32'(aqmeas_data),    32'd0);
        chk("rst_round",   32'(round_idx),      32'd0);
        chk("rst_ovf",     32'(ovf_err),        32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_ready", 32'(meas_ready), 32'd0);

        // Fill to four, fifth round dropped
        esm_start = 1'b1; step(); esm_start = 1'b0;
        chk("active_ready", 32'(meas_ready), 32'd1);
        for (int k = 1; k <= 4; k++) push(16'(k));
        chk("full_counter", 32'(aqmeas_counter), 32'd4);
        chk("full_ready",   32'(meas_ready),     32'd0);
        chk("full_ovf",     32'(ovf_err),        32'd0);
        push(16'h0005);
        chk("ovf_set",      32'(ovf_err),        32'd1);
        chk("ovf_counter",  32'(aqmeas_counter), 32'd4);
        chk("ovf_round",    32'(round_idx),      32'd4);
        for (int k = 1; k <= 4; k++) begin
            chk("fill_order", 32'(aqmeas_data), 32'(k));
            pop_aqmeasbuf = 1'b1; step(); pop_aqmeasbuf = 1'b0;
        end
        chk("drained_valid",   32'(aqmeas_valid),   32'd0);
        chk("drained_counter", 32'(aqmeas_counter), 32'd0);
        chk("ovf_sticky",      32'(ovf_err),        32'd1);
        rst_n = 1'b0; #2; rst_n = 1'b1;
        step();
        chk("ovf_cleared", 32'(ovf_err), 32'd0);

        // Single push, pop one cycle later, then pop on empty
        esm_start = 1'b1; step(); esm_start = 1'b0;
        push(16'h00F0);
        chk("single_valid",   32'(aqmeas_valid),   32'd1);
        chk("single_counter", 32'(aqmeas_counter), 32'd1);
        chk("single_data",    32'(aqmeas_data),    32'h00F0);
        pop_aqmeasbuf = 1'b1; step();
        chk("single_popped_valid",   32'(aqmeas_valid),   32'd0);
        chk("single_popped_counter", 32'(aqmeas_counter), 32'd0);
        step(); pop_aqmeasbuf = 1'b0;
        chk("empty_pop_counter", 32'(aqmeas_counter), 32'd0);
        chk("empty_pop_ovf",     32'(ovf_err),        32'd0);

        // esm_finish in ACTIVE returns to IDLE
        esm_finish = 1'b1; step(); esm_finish = 1'b0;
        chk("finish_round", 32'(round_idx),  32'd0);
        chk("finish_ready", 32'(meas_ready), 32'd0);

        // Full + simultaneous push/pop, fifth round enters DRAIN
        esm_start = 1'b1; step(); esm_start = 1'b0;
        for (int k = 1; k <= 4; k++) push(16'h0A00 + 16'(k));
        chk("pp_full_counter", 32'(aqmeas_counter), 32'd4);
        meas_valid = 1'b1; meas_data = 16'h0A05; pop_aqmeasbuf = 1'b1;
        #1;
        chk("pp_ready", 32'(meas_ready), 32'd1);
        step(); meas_valid = 1'b0; pop_aqmeasbuf = 1'b0;
        chk("pp_counter", 32'(aqmeas_counter), 32'd4);
        chk("pp_ovf",     32'(ovf_err),        32'd0);
        chk("pp_round",   32'(round_idx),      32'd5);
        for (int k = 2; k <= 5; k++) begin
            chk("pp_order", 32'(aqmeas_data), 32'h0A00 + 32'(k));
            pop_aqmeasbuf = 1'b1; step(); pop_aqmeasbuf = 1'b0;
        end
        chk("drain_ready",   32'(meas_ready),     32'd0);
        chk("drain_counter", 32'(aqmeas_counter), 32'd0);
        chk("drain_round",   32'(round_idx),      32'd5);
        esm_finish = 1'b1; step(); esm_finish = 1'b0;
        chk("drain_finish_round", 32'(round_idx),  32'd0);
        chk("drain_finish_ready", 32'(meas_ready), 32'd0);
        esm_start = 1'b1; step(); esm_start = 1'b0;
        chk("reopen_ready", 32'(meas_ready), 32'd1);

        // Raw versus detection-event storage
`ifdef AQMEAS_DIFF_EN
        diff_exp[0] = 16'h000F; diff_exp[1] = 16'h0000; diff_exp[2] = 16'h00F0;
`else
        diff_exp[0] = 16'h000F; diff_exp[1] = 16'h000F; diff_exp[2] = 16'h00FF;
`endif
        push(16'h000F); push(16'h000F); push(16'h00FF);
        chk("entry_counter", 32'(aqmeas_counter), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk("entry_value", 32'(aqmeas_data), 32'(diff_exp[k]));
            pop_aqmeasbuf = 1'b1; step(); pop_aqmeasbuf = 1'b0;
        end

        // Asynchronous reset with three entries buffered
        esm_finish = 1'b1; step(); esm_finish = 1'b0;
        esm_start = 1'b1; step(); esm_start = 1'b0;
        push(16'h1111); push(16'h2222); push(16'h3333);
        chk("pre_arst_counter", 32'(aqmeas_counter), 32'd3);
        #2; rst_n = 1'b0; #1;
        chk("arst_ready",   32'(meas_ready),     32'd0);
        chk("arst_valid",   32'(aqmeas_valid),   32'd0);
        chk("arst_counter", 32'(aqmeas_counter), 32'd0);
        chk("arst_data",    32'(aqmeas_data),    32'd0);
        chk("arst_round",   32'(round_idx),      32'd0);
        chk("arst_ovf",     32'(ovf_err),        32'd0);
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
